square_asm: RTL and testbench

- Multi-cycle integer squarer (shift-and-add ASM); computes result = a*a.
- Inverse companion of the sqrt_ASM core: squares a root to check or reconstruct a radicand.
- Uses the same init/done handshake as the sqrt core, so the same bus wrapper and firmware polling loop drive it.
- Control FSM and datapath live in one module.

---
 rtl/square_asm.sv | 115 +++++++++++
 tb/tb_square_asm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/square_asm.sv
// Multi-cycle shift-and-add squarer (result = a*a) with the sqrt core's init/done handshake.
// Optional SQUARE_ACCUM_EN adds an accum input: result = old_result + a*a (mod 2^(2*WIDTH)).
module square_asm #(
    parameter int WIDTH     = 16,
    parameter int DONE_HOLD = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
`ifdef SQUARE_ACCUM_EN
    input  logic                 accum,
`endif
    input  logic [WIDTH-1:0]     a,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_dbg
);

    // Handshake: init is sampled only in IDLE; done is a level held for DONE_HOLD
    // cycles while result is valid, and busy stays high until the FSM is back in IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_END   = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [3:0]           hold_q, hold_d;
    logic [2*WIDTH-1:0]   start_acc;

`ifdef SQUARE_ACCUM_EN
    assign start_acc = accum ? acc_q : '0;
`else
    assign start_acc = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hold_d   = hold_q;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (init) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = a;
                    acc_d    = start_acc;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mplier_q == '0)
                    state_d = S_END;
                else if (mplier_q[0])
                    state_d = S_ADD;
                else
                    state_d = S_SHIFT;
            end
            S_ADD: begin
                acc_d   = acc_q + mcand_q;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                state_d  = S_CHECK;
            end
            S_END: begin
                done = 1'b1;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign result    = acc_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_square_asm.sv
// Self-checking bench for square_asm: directed operands, scoreboard queue, done-edge monitor.
// Build with +define+SQUARE_ACCUM_EN to also exercise the accumulate mode.
module tb_square_asm;

    localparam int WIDTH     = 16;
    localparam int DONE_HOLD = 10;

    logic                 clk;
    logic                 rst;
    logic                 init;
    logic [WIDTH-1:0]     a;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 done;
    logic [2:0]           state_dbg;
`ifdef SQUARE_ACCUM_EN
    logic                 accum;
`endif

    square_asm #(.WIDTH(WIDTH), .DONE_HOLD(DONE_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
`ifdef SQUARE_ACCUM_EN
        .accum     (accum),
`endif
        .a         (a),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    // scoreboard state
    logic [2*WIDTH-1:0] exp_q[$];
    int                 lat_q[$];
    int                 acc_edge_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic start(input logic [WIDTH-1:0] val, input logic acc_mode,
                         input logic [2*WIDTH-1:0] exp, input int lat, input bit push);
        @(negedge clk);
        a    = val;
        init = 1'b1;
`ifdef SQUARE_ACCUM_EN
        accum = acc_mode;
`else
        if (acc_mode) $display("note: accum request ignored in base build");
`endif
        if (push) begin
            exp_q.push_back(exp);
            lat_q.push_back(lat);
            acc_edge_q.push_back(edge_cnt + 1);
        end
        @(negedge clk);
        init = 1'b0;
`ifdef SQUARE_ACCUM_EN
        accum = 1'b0;
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // monitor: compares on the rising edge of done, and the hold length on its fall
    logic               done_prev = 1'b0;
    int                 hold_cnt  = 0;
    logic [2*WIDTH-1:0] done_result = '0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_cnt  = 0;
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                done_result = result;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    logic [2*WIDTH-1:0] e;
                    int l, ae;
                    e  = exp_q.pop_front();
                    l  = lat_q.pop_front();
                    ae = acc_edge_q.pop_front();
                    check("result", 64'(result), 64'(e));
                    check("latency", 64'(edge_cnt - ae + 1), 64'(l));
                end
            end
            if (done) begin
                hold_cnt++;
                if (!busy) check("busy_with_done", 64'(busy), 64'd1);
            end
            if (!done && done_prev) begin
                check("done_hold", 64'(hold_cnt), 64'(DONE_HOLD));
                check("busy_after_done", 64'(busy), 64'd0);
                check("result_stable", 64'(result), 64'(done_result));
                hold_cnt = 0;
            end
            done_prev = done;
        end
    end

    initial begin
        rst  = 1'b0;
        init = 1'b0;
        a    = '0;
`ifdef SQUARE_ACCUM_EN
        accum = 1'b0;
`endif
        cycles(3);
        check("reset_result", 64'(result), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_state", 64'(state_dbg), 64'd0);
        rst = 1'b1;
        cycles(2);

        // abort mid-computation with an asynchronous reset between edges
        start(16'h00FF, 1'b0, '0, 0, 1'b0);
        cycles(10);
        check("abort_busy_before", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_result", 64'(result), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        start(16'd2, 1'b0, 32'd4, 7, 1'b1);
        wait_idle();

        // zero, typical and maximum operands
        start(16'd0, 1'b0, 32'd0, 2, 1'b1);
        wait_idle();
        start(16'd13, 1'b0, 32'h0000_00A9, 13, 1'b1);
        wait_idle();
        start(16'hFFFF, 1'b0, 32'hFFFE_0001, 50, 1'b1);
        wait_idle();

        // init while busy and while done must be ignored; a changes after capture
        start(16'd5, 1'b0, 32'd25, 10, 1'b1);
        cycles(2);
        a    = 16'd7;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        begin
            int n = 0;
            while (!done && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        cycles(2);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        wait_idle();
        cycles(4);
        check("ignored_init_result", 64'(result), 64'd25);
        check("ignored_init_idle", 64'(busy), 64'd0);

        // init held high re-triggers on the first IDLE cycle after done falls
        @(negedge clk);
        a    = 16'd3;
        init = 1'b1;
        exp_q.push_back(32'd9);
        lat_q.push_back(8);
        acc_edge_q.push_back(edge_cnt + 1);
        exp_q.push_back(32'd9);
        lat_q.push_back(8);
        acc_edge_q.push_back(edge_cnt + 1 + 8 + DONE_HOLD);
        cycles(8 + DONE_HOLD + 3);
        check("retrigger_busy", 64'(busy), 64'd1);
        init = 1'b0;
        wait_idle();

`ifdef SQUARE_ACCUM_EN
        start(16'd3, 1'b0, 32'd9, 8, 1'b1);
        wait_idle();
        start(16'd4, 1'b1, 32'd25, 9, 1'b1);
        wait_idle();
        start(16'hFFFF, 1'b1, 32'hFFFE_001A, 50, 1'b1);
        wait_idle();
`endif

        cycles(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
